perf_counter_reader: RTL

Snapshot-and-stream readout unit for the core's performance counters. It sits on the consumer side of the performance monitor. On request it captures all counter values in one cycle into shadow registers, then streams them as indexed words over a valid/ready interface to a debug or UART/trace sink. This lets counters be extracted from hardware runs without simulation-only file dumps.

---
 rtl/perf_pkg.sv | 25 ++
 rtl/perf_xor_fold.sv | 20 ++
 rtl/perf_counter_reader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared constants, counter order and FSM encoding for the performance-counter readout path.
// Latency/backpressure: n/a (declarations only).
package perf_pkg;

    localparam int PERF_NUM_CTRS  = 9;
    localparam int PERF_CTR_W     = 32;
    localparam int PERF_CYCLE_ADJ = 10;
    localparam int PERF_IDX_W     = 4;

    localparam int PERF_IDX_CYCLES         = 0;
    localparam int PERF_IDX_INSTRUCTIONS   = 1;
    localparam int PERF_IDX_STALLS         = 2;
    localparam int PERF_IDX_BUBBLES        = 3;
    localparam int PERF_IDX_FORWARDS       = 4;
    localparam int PERF_IDX_RAW_HAZARDS    = 5;
    localparam int PERF_IDX_COND_BRANCHES  = 6;
    localparam int PERF_IDX_UNCOND_BRANCHES = 7;
    localparam int PERF_IDX_COND_MISPRED   = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } perf_state_e;

endpackage

// File: rtl/perf_xor_fold.sv
// Combinational XOR reduction of NUM_W packed words into one word.
// Latency: 0 cycles; no flow control.
module perf_xor_fold
    import perf_pkg::*;
#(
    parameter int NUM_W = PERF_NUM_CTRS,
    parameter int W     = PERF_CTR_W
) (
    input  logic [NUM_W*W-1:0] words_i,
    output logic [W-1:0]       fold_o
);

    always_comb begin
        fold_o = '0;
        for (int i = 0; i < NUM_W; i++) begin
            fold_o = fold_o ^ words_i[i*W +: W];
        end
    end

endmodule

// File: rtl/perf_counter_reader.sv
// Snapshots all perf counters in one edge, then streams them as indexed words; word 0 on the cycle after snap_req.
// Stream stalls in place while out_ready is low; PERF_READER_CHECKSUM_EN appends an XOR checksum word.
module perf_counter_reader
    import perf_pkg::*;
#(
    parameter int NUM_CTRS  = PERF_NUM_CTRS,
    parameter int CTR_W     = PERF_CTR_W,
    parameter int CYCLE_ADJ = PERF_CYCLE_ADJ,
    parameter int IDX_W     = PERF_IDX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      snap_req,
    input  logic [NUM_CTRS*CTR_W-1:0] ctr_in,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          out_index,
    output logic [CTR_W-1:0]          out_data,
    output logic                      out_last,
    output logic [7:0]                drop_cnt
);

`ifdef PERF_READER_CHECKSUM_EN
    localparam int LAST_WORD = NUM_CTRS;
`else
    localparam int LAST_WORD = NUM_CTRS - 1;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_WORD);
    localparam logic [CTR_W-1:0] ADJ      = CTR_W'(CYCLE_ADJ);

    perf_state_e               state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_CTRS*CTR_W-1:0] shadow_q;
    logic [NUM_CTRS*CTR_W-1:0] tx_words;
    logic [7:0]                drop_cnt_q;
    logic [CTR_W-1:0]          cyc_raw;
    logic [CTR_W-1:0]          word_sel;
    logic                      capture;
    logic                      drop;
    logic                      is_last;

    // Words exactly as they go on the wire: cycle count trimmed by the readout overhead.
    assign cyc_raw = shadow_q[PERF_IDX_CYCLES*CTR_W +: CTR_W];

    always_comb begin
        tx_words = shadow_q;
        tx_words[PERF_IDX_CYCLES*CTR_W +: CTR_W] = (cyc_raw > ADJ) ? (cyc_raw - ADJ) : cyc_raw;
    end

`ifdef PERF_READER_CHECKSUM_EN
    logic [CTR_W-1:0] csum;

    perf_xor_fold #(
        .NUM_W (NUM_CTRS),
        .W     (CTR_W)
    ) u_xor_fold (
        .words_i (tx_words),
        .fold_o  (csum)
    );
`endif

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                word_sel = tx_words[i*CTR_W +: CTR_W];
            end
        end
`ifdef PERF_READER_CHECKSUM_EN
        if (idx_q == IDX_W'(NUM_CTRS)) begin
            word_sel = csum;
        end
`endif
    end

    assign is_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        capture   = 1'b0;
        drop      = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (snap_req) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = is_last;
                if (out_ready && is_last) begin
                    // A request landing on the final transfer restarts with no idle gap.
                    idx_d = '0;
                    if (snap_req) begin
                        capture = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    drop = snap_req;
                    if (out_ready) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_index = idx_q;
    assign out_data  = out_valid ? word_sel : '0;
    assign drop_cnt  = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            shadow_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                shadow_q <= ctr_in;
            end
            if (drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

endmodule
